// File: rtl/sp_param_core.sv
// sp_param_core: parametrised multi-cycle core, one instruction per handshake.
// Ports: in_valid/inst in, out_valid/err/inst_addr out, dmem req/ack data port.
module sp_param_core #(
  parameter int DATA_W      = 32,
  parameter int REG_NUM     = 32,
  parameter int ADDR_W      = 32,
  parameter int DMEM_AW     = 12,
  parameter int R0_ZERO     = 0,
  parameter int MEM_TIMEOUT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        inst,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  inst_addr,
  output logic               err,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_MEM, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DMEM_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rf_q [REG_NUM];
  logic [DATA_W-1:0]   rf_d [REG_NUM];

  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = inst_q[31:26];
  assign rs    = inst_q[25:21];
  assign rt    = inst_q[20:16];
  assign rd    = inst_q[15:11];
  assign shamt = inst_q[10:6];
  assign func  = inst_q[5:0];
  assign imm   = inst_q[15:0];

  // 32-entry read view: unimplemented indices and a hardwired r0 read 0
  logic [DATA_W-1:0] rd_view [32];

  for (genvar g = 0; g < 32; g++) begin : g_view
    if (g < REG_NUM) begin : g_imp
      assign rd_view[g] =
        (R0_ZERO != 0 && g == 0) ? '0 : rf_q[g];
    end else begin : g_nul
      assign rd_view[g] = '0;
    end
  end

  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] imm_z, imm_s;

  assign rs_val = rd_view[rs];
  assign rt_val = rd_view[rt];
  assign imm_z  = DATA_W'(imm);
  assign imm_s  = DATA_W'($signed(imm));

  logic is_r, is_alui, is_lw, is_sw;
  logic is_br, is_lui, is_j, illegal;

  assign is_r    = (op == 6'd0) && (func <= 6'd8);
  assign is_alui = (op >= 6'd1) && (op <= 6'd4);
  assign is_lw   = (op == 6'd5);
  assign is_sw   = (op == 6'd6);
  assign is_br   = (op == 6'd7) || (op == 6'd8);
  assign is_lui  = (op == 6'd9);
  assign is_j    = (op == 6'd10);
  assign illegal = !(is_r | is_alui | is_lw | is_sw |
                     is_br | is_lui | is_j);

  logic [DATA_W-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    if (op == 6'd0) begin
      case (func)
        6'd0:    alu_res = rs_val & rt_val;
        6'd1:    alu_res = rs_val | rt_val;
        6'd2:    alu_res = rs_val + rt_val;
        6'd3:    alu_res = rs_val - rt_val;
        6'd4:    alu_res = DATA_W'($signed(rs_val) <
                                   $signed(rt_val));
        6'd5:    alu_res = rs_val << shamt;
        6'd6:    alu_res = ~(rs_val | rt_val);
        6'd7:    alu_res = rs_val >> shamt;
        6'd8:    alu_res = $signed(rs_val) >>> shamt;
        default: alu_res = '0;
      endcase
    end else begin
      case (op)
        6'd1:    alu_res = rs_val & imm_z;
        6'd2:    alu_res = rs_val | imm_z;
        6'd3:    alu_res = rs_val + imm_s;
        6'd4:    alu_res = rs_val - imm_s;
        6'd9:    alu_res = imm_z << (DATA_W - 16);
        default: alu_res = '0;
      endcase
    end
  end

  // one extra bit so the signed sum never overflows
  logic signed [DATA_W:0] ea;
  logic                   ea_ok;

  assign ea = $signed({rs_val[DATA_W-1], rs_val}) +
              $signed({imm_s[DATA_W-1], imm_s});
  assign ea_ok = !ea[DATA_W] &&
                 ((ea[DATA_W-1:0] >> DMEM_AW) == '0);

  logic [ADDR_W-1:0] pc_seq, br_off, br_tgt;
  logic [ADDR_W-1:0] j_tgt, pc_exec;
  logic              br_taken;

  assign pc_seq   = pc_q + ADDR_W'(4);
  assign br_off   = ADDR_W'($signed(imm)) << 2;
  assign br_tgt   = pc_seq + br_off;
  assign j_tgt    = ADDR_W'({inst_q[25:0], 2'b00});
  assign br_taken = (op == 6'd7) ? (rs_val == rt_val)
                                 : (rs_val != rt_val);

  always_comb begin
    pc_exec = pc_seq;
    unique case (1'b1)
      is_j:              pc_exec = j_tgt;
      is_br && br_taken: pc_exec = br_tgt;
      default:           ;
    endcase
  end

  logic              wr_en;
  logic [4:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = rt;
    wr_data     = alu_res;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          inst_d  = inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((is_lw || is_sw) && ea_ok) begin
          req_d   = 1'b1;
          we_d    = is_sw;
          addr_d  = ea[DMEM_AW-1:0];
          wdata_d = rt_val;
          cnt_d   = CW'(1);
          state_d = S_MEM;
        end else begin
          out_valid_d = 1'b1;
          err_d       = illegal || is_lw || is_sw;
          pc_d        = pc_exec;
          wr_en       = is_r || is_alui || is_lui;
          wr_idx      = is_r ? rd : rt;
          state_d     = S_DONE;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          req_d       = 1'b0;
          out_valid_d = 1'b1;
          pc_d        = pc_seq;
          wr_en       = !we_q;
          wr_data     = dmem_rdata;
          state_d     = S_DONE;
        end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
          req_d       = 1'b0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          pc_d        = pc_seq;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  // out-of-range indices match no entry, so their writes vanish
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      rf_d[i] = rf_q[i];
      if (wr_en && wr_idx == 5'(i) &&
          !(R0_ZERO != 0 && i == 0))
        rf_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < REG_NUM; i++)
        rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rf_q        <= rf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign inst_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_sp_param_core.sv
// tb_sp_param_core: random and directed stimulus for sp_param_core.
// Default instance vs a reference model; 16-bit variant vs constants.
module tb_sp_param_core;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        out_valid, err, dmem_req, dmem_we;
  logic [31:0] inst_addr, dmem_wdata;
  logic [11:0] dmem_addr;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic        in_valid16 = 1'b0;
  logic [31:0] inst16 = '0;
  logic        out_valid16, err16, dmem_req16, dmem_we16;
  logic [31:0] inst_addr16;
  logic [11:0] dmem_addr16;
  logic [15:0] dmem_wdata16;
  logic        dmem_ack16 = 1'b0;
  logic [15:0] dmem_rdata16 = '0;

  int checks = 0;
  int fails = 0;

  logic [31:0] model_r [32];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  sp_param_core dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .inst(inst),
    .out_valid(out_valid), .inst_addr(inst_addr),
    .err(err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  sp_param_core #(
    .DATA_W(16), .REG_NUM(8), .R0_ZERO(1)
  ) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .inst(inst16),
    .out_valid(out_valid16), .inst_addr(inst_addr16),
    .err(err16), .dmem_req(dmem_req16),
    .dmem_we(dmem_we16), .dmem_addr(dmem_addr16),
    .dmem_wdata(dmem_wdata16), .dmem_ack(dmem_ack16),
    .dmem_rdata(dmem_rdata16)
  );

  task automatic model_reset();
    for (int k = 0; k < 32; k++) model_r[k] = '0;
    model_pc = '0;
  endtask

  function automatic int first_bad();
    for (int k = 0; k < 32; k++)
      if (dut.rf_q[k] !== model_r[k]) return k;
    return -1;
  endfunction

  // Architectural reference: spec rules with wide integer math.
  task automatic model_exec(
    input  logic [31:0] i, input bit acked,
    input  logic [31:0] rdata,
    output bit e_err, output bit e_issue,
    output logic [11:0] e_addr, output bit e_we,
    output logic [31:0] e_wd);
    int op, rs, rt, rd, sh, fn, dst;
    longint a, b, sa, sb, simm, zimm, ea, res, p, npc;
    bit wr;
    op = int'(i[31:26]); rs = int'(i[25:21]);
    rt = int'(i[20:16]); rd = int'(i[15:11]);
    sh = int'(i[10:6]);  fn = int'(i[5:0]);
    a = longint'(model_r[rs]);
    b = longint'(model_r[rt]);
    sa = longint'($signed(model_r[rs]));
    sb = longint'($signed(model_r[rt]));
    simm = longint'($signed(i[15:0]));
    zimm = longint'(i[15:0]);
    p = 64'd1 << sh;
    e_err = 0; e_issue = 0; e_addr = '0;
    e_we = 0; e_wd = '0; wr = 0; dst = 0; res = 0;
    npc = longint'(model_pc) + 4;
    if (op == 0) begin
      dst = rd; wr = 1;
      case (fn)
        0: res = a & b;
        1: res = a | b;
        2: res = a + b;
        3: res = a - b;
        4: res = (sa < sb) ? 1 : 0;
        5: res = a * p;
        6: res = ~(a | b);
        7: res = a / p;
        8: res = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        default: begin wr = 0; e_err = 1; end
      endcase
    end else begin
      case (op)
        1: begin wr = 1; dst = rt; res = a & zimm; end
        2: begin wr = 1; dst = rt; res = a | zimm; end
        3: begin wr = 1; dst = rt; res = a + simm; end
        4: begin wr = 1; dst = rt; res = a - simm; end
        5, 6: begin
          ea = sa + simm;
          if (ea < 0 || ea >= 4096) e_err = 1;
          else begin
            e_issue = 1;
            e_addr = ea[11:0];
            e_we = (op == 6);
            e_wd = model_r[rt];
            if (!acked) e_err = 1;
            else if (op == 5) begin
              wr = 1; dst = rt; res = longint'(rdata);
            end
          end
        end
        7: if (a == b) npc = longint'(model_pc) + 4 + simm * 4;
        8: if (a != b) npc = longint'(model_pc) + 4 + simm * 4;
        9: begin wr = 1; dst = rt; res = zimm * 65536; end
        10: npc = longint'(i[25:0]) * 4;
        default: e_err = 1;
      endcase
    end
    if (wr) model_r[dst] = res[31:0];
    model_pc = npc[31:0];
  endtask

  // Issues one instruction and follows it to out_valid.
  // ack_k: req cycle that gets ack (0 = never).
  task automatic drive(
    input logic [31:0] i, input int ack_k,
    input logic [31:0] rdv,
    output int lat, output int nreq, output bit e,
    output bit stable, output logic [11:0] a0,
    output bit we0, output logic [31:0] wd0);
    int c;
    bit done;
    c = 0; nreq = 0; lat = -1; e = 0; stable = 1;
    a0 = '0; we0 = 0; wd0 = '0; done = 0;
    @(negedge clk);
    in_valid = 1'b1; inst = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0; inst = $urandom;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (out_valid) begin
        lat = c - 1; e = err; done = 1;
        dmem_ack = 1'b0; in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        inst = $urandom;
        if (dmem_req) begin
          nreq++;
          if (nreq == 1) begin
            a0 = dmem_addr; we0 = dmem_we; wd0 = dmem_wdata;
          end else if (dmem_addr !== a0 || dmem_we !== we0 ||
                       dmem_wdata !== wd0) stable = 0;
          dmem_ack = (nreq == ack_k);
          dmem_rdata = (nreq == ack_k) ? rdv : $urandom;
        end else begin
          dmem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drive16(input logic [31:0] i,
                         output int lat, output bit e);
    int c;
    c = 0; lat = -1; e = 0;
    @(negedge clk);
    in_valid16 = 1'b1; inst16 = i;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    while (lat < 0 && c < 20) begin
      @(negedge clk);
      c++;
      if (out_valid16) begin lat = c - 1; e = err16; end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, err, dmem_req, dmem_we} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000",
               {out_valid, err, dmem_req, dmem_we});
    end
    checks++;
    if (inst_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc: got %h want 0", inst_addr);
    end
    checks++;
    if (dmem_addr !== 12'h0 || dmem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_dmem: addr %h wdata %h want 0",
               dmem_addr, dmem_wdata);
    end
    model_reset();
    bad = first_bad();
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL reset_regs: r%0d got %h want %h",
               bad, dut.rf_q[bad], model_r[bad]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_slt();
    logic [31:0] prog [3];
    logic [31:0] xval [3];
    int lat, nreq, bad;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd;
    prog[0] = {6'd3, 5'd0, 5'd1, 16'hFFFB};
    prog[1] = {6'd0, 5'd1, 5'd1, 5'd2, 5'd0, 6'd2};
    prog[2] = {6'd0, 5'd1, 5'd0, 5'd3, 5'd0, 6'd4};
    xval[0] = 32'hFFFFFFFB;
    xval[1] = 32'hFFFFFFF6;
    xval[2] = 32'h1;
    for (int n = 0; n < 3; n++) begin
      drive(prog[n], 0, '0, lat, nreq, e, st, a0, we0, wd0);
      model_exec(prog[n], 0, '0, xe, xi, xa, xwe, xwd);
      checks++;
      if (lat !== 1 || e !== 1'b0) begin
        fails++;
        $display("FAIL add_slt_lat%0d: lat %0d err %b want 1 0",
                 n, lat, e);
      end
      checks++;
      if (inst_addr !== 32'(4 * (n + 1))) begin
        fails++;
        $display("FAIL add_slt_pc%0d: got %h want %h",
                 n, inst_addr, 4 * (n + 1));
      end
      checks++;
      if (dut.rf_q[n + 1] !== xval[n]) begin
        fails++;
        $display("FAIL add_slt_r%0d: got %h want %h",
                 n + 1, dut.rf_q[n + 1], xval[n]);
      end
      bad = first_bad();
      checks++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL add_slt_regs: r%0d got %h want %h",
                 bad, dut.rf_q[bad], model_r[bad]);
      end
    end
  endtask

  task automatic test_branch_jump();
    int lat, nreq;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd, i;
    i = {6'd8, 5'd1, 5'd0, 16'hFFFE};
    drive(i, 0, '0, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 0, '0, xe, xi, xa, xwe, xwd);
    checks++;
    if (inst_addr !== 32'h8 || lat !== 1 || e !== 1'b0) begin
      fails++;
      $display("FAIL bne_taken: pc %h lat %0d err %b want 8 1 0",
               inst_addr, lat, e);
    end
    i = {6'd10, 26'h40};
    drive(i, 0, '0, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 0, '0, xe, xi, xa, xwe, xwd);
    checks++;
    if (inst_addr !== 32'h100 || lat !== 1 || e !== 1'b0) begin
      fails++;
      $display("FAIL jump: pc %h lat %0d err %b want 100 1 0",
               inst_addr, lat, e);
    end
  endtask

  task automatic test_load_wait();
    int lat, nreq;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd, i, rdv;
    i = {6'd5, 5'd0, 5'd4, 16'd3};
    rdv = 32'hA5C30F17;
    drive(i, 3, rdv, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 1, rdv, xe, xi, xa, xwe, xwd);
    checks++;
    if (a0 !== 12'd3 || nreq !== 3 || !st || we0 !== 1'b0) begin
      fails++;
      $display("FAIL lw_req: addr %h n %0d st %b we %b want 3 3 1 0",
               a0, nreq, st, we0);
    end
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      fails++;
      $display("FAIL lw_lat: lat %0d err %b want 4 0", lat, e);
    end
    checks++;
    if (dut.rf_q[4] !== rdv || inst_addr !== 32'h104) begin
      fails++;
      $display("FAIL lw_wb: r4 %h pc %h want %h 104",
               dut.rf_q[4], inst_addr, rdv);
    end
  endtask

  task automatic test_timeout_range();
    int lat, nreq, bad;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd, i;
    i = {6'd6, 5'd0, 5'd2, 16'd0};
    drive(i, 0, '0, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 0, '0, xe, xi, xa, xwe, xwd);
    checks++;
    if (lat !== 1 + TMO || e !== 1'b1 || nreq !== TMO) begin
      fails++;
      $display("FAIL sw_timeout: lat %0d err %b n %0d want %0d 1 %0d",
               lat, e, nreq, 1 + TMO, TMO);
    end
    checks++;
    if (we0 !== 1'b1 || wd0 !== 32'hFFFFFFF6 || !st ||
        inst_addr !== 32'h108) begin
      fails++;
      $display("FAIL sw_fields: we %b wd %h st %b pc %h",
               we0, wd0, st, inst_addr);
    end
    bad = first_bad();
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL sw_timeout_regs: r%0d got %h want %h",
               bad, dut.rf_q[bad], model_r[bad]);
    end
    i = {6'd5, 5'd0, 5'd5, 16'h1000};
    drive(i, 1, 32'h1234, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 1, 32'h1234, xe, xi, xa, xwe, xwd);
    checks++;
    if (nreq !== 0 || lat !== 1 || e !== 1'b1 ||
        inst_addr !== 32'h10C) begin
      fails++;
      $display("FAIL lw_range: n %0d lat %0d err %b pc %h",
               nreq, lat, e, inst_addr);
    end
    bad = first_bad();
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL lw_range_regs: r%0d got %h want %h",
               bad, dut.rf_q[bad], model_r[bad]);
    end
  endtask

  task automatic test_random();
    int lat, nreq, bad, kind, ack_k, xlat, xn;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd, i, rdv;
    logic [5:0] op;
    logic [4:0] base, rs;
    logic [15:0] imm;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      ack_k = 0;
      rdv = $urandom;
      case (kind)
        1: i = {6'($urandom_range(1, 4)), 5'($urandom),
                5'($urandom_range(1, 29)), 16'($urandom)};
        2: i = {6'd9, 5'($urandom),
                5'($urandom_range(1, 29)), 16'($urandom)};
        3, 4: begin
          op = (kind == 3) ? 6'd5 : 6'd6;
          base = ($urandom_range(0, 1) != 0) ? 5'd30
                                             : 5'($urandom);
          imm = ($urandom_range(0, 9) < 7)
                ? 16'($urandom_range(0, 4095)) : 16'($urandom);
          i = {op, base,
               (kind == 3) ? 5'($urandom_range(1, 29))
                           : 5'($urandom), imm};
          ack_k = $urandom_range(0, 4);
        end
        5: begin
          rs = 5'($urandom);
          i = {($urandom_range(0, 1) != 0) ? 6'd7 : 6'd8, rs,
               ($urandom_range(0, 1) != 0) ? rs : 5'($urandom),
               16'($urandom)};
        end
        6: i = {6'd10, 26'($urandom)};
        7: i = ($urandom_range(0, 1) != 0)
               ? {6'($urandom_range(11, 63)), 26'($urandom)}
               : {6'd0, 20'($urandom), 6'($urandom_range(9, 63))};
        default: i = {6'd0, 5'($urandom), 5'($urandom),
                      5'($urandom_range(1, 29)), 5'($urandom),
                      6'($urandom_range(0, 8))};
      endcase
      drive(i, ack_k, rdv, lat, nreq, e, st, a0, we0, wd0);
      model_exec(i, ack_k != 0, rdv, xe, xi, xa, xwe, xwd);
      xlat = !xi ? 1 : (ack_k != 0 ? 1 + ack_k : 1 + TMO);
      xn = !xi ? 0 : (ack_k != 0 ? ack_k : TMO);
      checks++;
      if (lat !== xlat || nreq !== xn) begin
        fails++;
        $display("FAIL rnd%0d_lat %h: lat %0d n %0d want %0d %0d",
                 n, i, lat, nreq, xlat, xn);
      end
      checks++;
      if (e !== xe) begin
        fails++;
        $display("FAIL rnd%0d_err %h: got %b want %b", n, i, e, xe);
      end
      checks++;
      if (inst_addr !== model_pc) begin
        fails++;
        $display("FAIL rnd%0d_pc %h: got %h want %h",
                 n, i, inst_addr, model_pc);
      end
      bad = first_bad();
      checks++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL rnd%0d_regs %h: r%0d got %h want %h",
                 n, i, bad, dut.rf_q[bad], model_r[bad]);
      end
      if (xi) begin
        checks++;
        if (a0 !== xa || we0 !== xwe || wd0 !== xwd || !st) begin
          fails++;
          $display("FAIL rnd%0d_req %h: a %h we %b wd %h st %b want %h %b %h 1",
                   n, i, a0, we0, wd0, st, xa, xwe, xwd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_req();
    int lat, nreq, bad;
    bit e, st, we0, xe, xi, xwe;
    logic [11:0] a0, xa;
    logic [31:0] wd0, xwd, i;
    dmem_ack = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    inst = {6'd5, 5'd30, 5'd5, 16'd1};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_req_pre: req %b want 1", dmem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, err, dmem_req, dmem_we} !== 4'b0 ||
        inst_addr !== 32'h0 || dmem_addr !== 12'h0 ||
        dmem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL mid_req_outs: %b %h %h %h want zeros",
               {out_valid, err, dmem_req, dmem_we},
               inst_addr, dmem_addr, dmem_wdata);
    end
    model_reset();
    bad = first_bad();
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL mid_req_regs: r%0d got %h want 0",
               bad, dut.rf_q[bad]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i = {6'd3, 5'd0, 5'd1, 16'd9};
    drive(i, 0, '0, lat, nreq, e, st, a0, we0, wd0);
    model_exec(i, 0, '0, xe, xi, xa, xwe, xwd);
    checks++;
    if (lat !== 1 || inst_addr !== 32'h4 ||
        dut.rf_q[1] !== 32'd9) begin
      fails++;
      $display("FAIL post_reset: lat %0d pc %h r1 %h want 1 4 9",
               lat, inst_addr, dut.rf_q[1]);
    end
  endtask

  task automatic test_param_variant();
    logic [31:0] prog [10];
    int          reg_ix [10];
    logic [15:0] xval [10];
    int lat;
    bit e, zero_ok;
    prog[0] = {6'd3, 5'd0, 5'd0, 16'd7};
    reg_ix[0] = 0; xval[0] = 16'h0000;
    prog[1] = {6'd3, 5'd0, 5'd9, 16'd1};
    reg_ix[1] = 1; xval[1] = 16'h0000;
    prog[2] = {6'd9, 5'd0, 5'd2, 16'h8000};
    reg_ix[2] = 2; xval[2] = 16'h8000;
    prog[3] = {6'd0, 5'd2, 5'd0, 5'd3, 5'd3, 6'd8};
    reg_ix[3] = 3; xval[3] = 16'hF000;
    prog[4] = {6'd0, 5'd2, 5'd0, 5'd5, 5'd20, 6'd8};
    reg_ix[4] = 5; xval[4] = 16'hFFFF;
    prog[5] = {6'd0, 5'd2, 5'd0, 5'd6, 5'd4, 6'd7};
    reg_ix[5] = 6; xval[5] = 16'h0800;
    prog[6] = {6'd0, 5'd2, 5'd0, 5'd6, 5'd20, 6'd7};
    reg_ix[6] = 6; xval[6] = 16'h0000;
    prog[7] = {6'd9, 5'd0, 5'd4, 16'h0012};
    reg_ix[7] = 4; xval[7] = 16'h0012;
    prog[8] = {6'd0, 5'd4, 5'd0, 5'd7, 5'd4, 6'd5};
    reg_ix[8] = 7; xval[8] = 16'h0120;
    prog[9] = {6'd0, 5'd4, 5'd0, 5'd7, 5'd17, 6'd5};
    reg_ix[9] = 7; xval[9] = 16'h0000;
    for (int n = 0; n < 10; n++) begin
      drive16(prog[n], lat, e);
      checks++;
      if (lat !== 1 || e !== 1'b0 ||
          inst_addr16 !== 32'(4 * (n + 1))) begin
        fails++;
        $display("FAIL p16_step%0d: lat %0d err %b pc %h",
                 n, lat, e, inst_addr16);
      end
      checks++;
      if (dut16.rf_q[reg_ix[n]] !== xval[n]) begin
        fails++;
        $display("FAIL p16_r%0d_step%0d: got %h want %h",
                 reg_ix[n], n, dut16.rf_q[reg_ix[n]], xval[n]);
      end
    end
    zero_ok = (dut16.rf_q[0] === 16'h0) &&
              (dut16.rf_q[1] === 16'h0);
    checks++;
    if (!zero_ok) begin
      fails++;
      $display("FAIL p16_drops: r0 %h r1 %h want 0 0",
               dut16.rf_q[0], dut16.rf_q[1]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_slt();
    test_branch_jump();
    test_load_wait();
    test_timeout_range();
    test_random();
    test_reset_mid_req();
    test_param_variant();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
